// File: rtl/uart_rx_word_if.sv
// uart_rx_word_if: serial input and word-level outputs of the
// 32-bit UART word receiver, grouped as one bundle.
interface uart_rx_word_if;
   logic        rx;
   logic [31:0] data_out;
   logic        data_valid;
   logic        frame_err;
   logic        busy;

   modport master (
      input  rx,
      output data_out,
      output data_valid,
      output frame_err,
      output busy
   );

   modport slave (
      output rx,
      input  data_out,
      input  data_valid,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 receiver assembling 4 bytes (LSB first) into a word.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_word #(
   parameter int CLKS_PER_BIT = 44,
   parameter int BYTE_TIMEOUT = 1024
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_word_if.master bus
);

   localparam logic [15:0] BIT_END  = 16'(CLKS_PER_BIT - 1);
   localparam logic [15:0] HALF_END = 16'(CLKS_PER_BIT / 2 - 1);
   localparam int          TW       = $clog2(BYTE_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_END = TW'(BYTE_TIMEOUT - 1);

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {
      IDLE, START, DATA, PARITY, STOP
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE, START, DATA, STOP
   } state_t;
`endif

   state_t        state;
   state_t        nstate;
   logic          sync1;
   logic          rxs;
   logic          rxs_d;
   logic [15:0]   baud;
   logic [2:0]    bitn;
   logic [7:0]    shift;
   logic [1:0]    idx;
   logic [23:0]   word;
   logic [TW-1:0] tcnt;
   logic [31:0]   dout;
   logic          dvalid;
   logic          ferr;

   logic          fall;
   logic          bit_end;
   logic          half_end;
   logic          timeout;
   logic          take;
   logic          accept;
   logic          bad_stop;
   logic          par_err;
   logic          drop;

`ifdef UART_RX_PARITY_EN
   logic          par_bad;
   assign drop = par_bad;
`else
   assign drop = 1'b0;
`endif

   assign fall     = rxs_d & ~rxs;
   assign bit_end  = (baud == BIT_END);
   assign half_end = (baud == HALF_END);
   assign timeout  = (state == IDLE) && (idx != 2'd0)
                     && (tcnt == TO_END);

   assign bus.data_out   = dout;
   assign bus.data_valid = dvalid;
   assign bus.frame_err  = ferr;
   assign bus.busy       = (state != IDLE) | (idx != 2'd0);

   // Two-flop synchroniser plus one-clock history for edge detect;
   // the history flop also blocks a start while the line stays low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= bus.rx;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nstate;
   end

   // Next state and per-cycle decisions of the frame decoder.
   always_comb begin
      nstate   = state;
      take     = 1'b0;
      accept   = 1'b0;
      bad_stop = 1'b0;
      par_err  = 1'b0;
      unique case (state)
         IDLE: begin
            if (fall) nstate = START;
         end
         START: begin
            if (half_end) nstate = rxs ? IDLE : DATA;
         end
         DATA: begin
            if (bit_end) begin
               take = 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bitn == 3'd7) nstate = PARITY;
`else
               if (bitn == 3'd7) nstate = STOP;
`endif
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               par_err = ^{shift, rxs};
               nstate  = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_end) begin
               nstate   = IDLE;
               accept   = rxs & ~drop;
               bad_stop = ~rxs & ~drop;
            end
         end
         default: nstate = IDLE;
      endcase
   end

   // Baud counter restarts on each state change, wraps per bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                 baud <= '0;
      else if (nstate != state) baud <= '0;
      else if (bit_end)         baud <= '0;
      else                      baud <= baud + 16'd1;
   end

   // Data bit counter and LSB-first shift register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bitn  <= '0;
         shift <= '0;
      end else if (take) begin
         bitn  <= bitn + 3'd1;
         shift <= {rxs, shift[7:1]};
      end else if (state != DATA) begin
         bitn  <= '0;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Remember a parity failure until the stop bit has passed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                              par_bad <= 1'b0;
      else if (state == PARITY && bit_end)   par_bad <= par_err;
   end
`endif

   // Inter-byte idle timer, only armed while a word is partial.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                                tcnt <= '0;
      else if (state != IDLE || idx == 2'd0)   tcnt <= '0;
      else if (timeout)                        tcnt <= '0;
      else                                     tcnt <= tcnt + 1'b1;
   end

   // Byte index: advance on accept, clear on error or timeout.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      idx <= '0;
      else if (timeout)              idx <= '0;
      else if (bad_stop | par_err)   idx <= '0;
      else if (accept)               idx <= idx + 2'd1;
   end

   // Word assembly; the 4th byte goes straight to the output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word   <= '0;
         dout   <= '0;
         dvalid <= 1'b0;
      end else begin
         dvalid <= 1'b0;
         if (accept) begin
            unique case (idx)
               2'd0: word[7:0]   <= shift;
               2'd1: word[15:8]  <= shift;
               2'd2: word[23:16] <= shift;
               default: begin
                  dout   <= {shift, word};
                  dvalid <= 1'b1;
               end
            endcase
         end
      end
   end

   // Framing error strobe.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ferr <= 1'b0;
      else      ferr <= bad_stop | par_err;
   end

endmodule
